hex_scan_ctrl: RTL and testbench
================================

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving the number of Clk cycles per digit slot; legal range 2..2^20.
REQ-002 The block SHALL have port Clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port Reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port Load, input, 1 bit, a request to capture Value for display.
REQ-005 The block SHALL have port Value, input, 16 bits, four hex nibbles, with digit 0 = Value[3:0].
REQ-006 The block SHALL have port Ack, output, 1 bit, a one-cycle pulse when a captured Value becomes the displayed value.
REQ-007 The block SHALL have port Nibble, output, 4 bits, the current digit's nibble, fed to the downstream hex-to-7-segment decoder.
REQ-008 The block SHALL have port DigitSel_n, output, 4 bits, an active-low one-hot digit enable.
REQ-009 The block SHALL have port Blank, output, 1 bit; when high, downstream forces all segments off.
REQ-010 The block SHALL have port FrameDone, output, 1 bit, a one-cycle pulse at the end of each 4-digit frame.

Function
REQ-011 The block SHALL implement states IDLE (nothing displayed) and SCAN (multiplexing).
REQ-012 In IDLE, the block SHALL hold the prescaler at 0, DigitSel_n=4'b1111, Blank=1, and Nibble=0.
REQ-013 IDLE with Load=1 SHALL copy Value to the shadow register, go to SCAN with digit index 0 and prescaler 0, and pulse Ack in the next cycle.
REQ-014 In SCAN, the prescaler SHALL count 0..SCAN_DIV-1 and wrap; a tick occurs on the cycle where the count equals SCAN_DIV-1.
REQ-015 On each tick, the digit index SHALL advance 0->1->2->3->0.
REQ-016 Nibble and DigitSel_n SHALL be registered: they reflect the new index one cycle after the tick, with DigitSel_n = ~(1<<idx) and Nibble = shadow[4*idx+3:4*idx].
REQ-017 A frame boundary SHALL be a tick while idx==3; FrameDone SHALL pulse in the following cycle.
REQ-018 In SCAN, Load=1 SHALL copy Value into a pending register and set the pending flag; a later Load before commit overwrites it (latest wins).
REQ-019 At a frame boundary with pending set, the block SHALL copy pending to the shadow register, clear the flag, and pulse Ack next cycle, so that digit 0 of the new frame shows new data.
REQ-020 When Load and a frame boundary coincide, Value SHALL go directly to the shadow register, pending is cleared, and Ack pulses next cycle.
REQ-021 Ack SHALL pulse at most once per frame boundary; a Load that is overwritten SHALL produce no Ack of its own.
REQ-022 Without blanking, the block SHALL hold Blank=0 throughout SCAN.

Reset
REQ-023 Reset=1 at any time, including mid-frame or with a commit pending, SHALL force on the next edge: IDLE, shadow=0, pending=0 with flag clear, idx=0, prescaler=0, Nibble=0, DigitSel_n=4'b1111, Blank=1, Ack=0, FrameDone=0.
REQ-024 Reset SHALL take priority over Load in the same cycle.

Configuration
REQ-025 With HEX_SCAN_LZ_BLANK_EN defined, in SCAN, Blank SHALL be 1 for digit idx>0 when shadow nibbles idx..3 are all zero; digit 0 is never blanked.
REQ-026 Without HEX_SCAN_LZ_BLANK_EN, Blank SHALL follow REQ-022, and no zero-detect logic is synthesized.

Structure
REQ-027 Package hex_pkg SHALL hold NUM_DIGITS=4, the typedef nibble_t (logic [3:0]), the typedef digit_idx_t (logic [1:0]), and the state enum scan_state_e {IDLE, SCAN}.
REQ-028 The prescaler SHALL be a sub-module scan_prescaler (parameter DIV; ports Clk, Reset, En, Tick).
REQ-029 The segment decoder SHALL stay outside this block.

Verification (SCAN_DIV=4)
REQ-030 Reset, then Load=1 with Value=16'h1A2F -> Ack pulses once; DigitSel_n sequence 1110/1101/1011/0111 with Nibble F/2/A/1, each held 4 cycles.
REQ-031 Mid-frame Load with 16'h0003, then Load with 16'h0004 -> one Ack, coincident with the FrameDone pulse; the next frame shows 4,0,0,0.
REQ-032 Load asserted exactly on the idx==3 tick -> direct commit; Ack and FrameDone pulse in the same cycle.
REQ-033 Reset asserted on idx=2 with a commit pending -> next cycle DigitSel_n=1111, Blank=1; no Ack follows.
REQ-034 With HEX_SCAN_LZ_BLANK_EN and Value=16'h0050 -> Blank=0 for digits 0 and 1, Blank=1 for digits 2 and 3; Value=16'h0000 -> only digit 0 unblanked.
REQ-035 Without the macro and Value=16'h0000 -> Blank=0 on all four digits.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared types, constants and helpers for the hex_scan_ctrl display multiplexer.
// The leading-zero helper exists only when HEX_SCAN_LZ_BLANK_EN is defined.
package hex_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] nibble_t;
  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    IDLE,
    SCAN
  } scan_state_e;

  function automatic nibble_t nibble_at(input logic [15:0] v, input digit_idx_t idx);
    return v[{idx, 2'b00} +: 4];
  endfunction

`ifdef HEX_SCAN_LZ_BLANK_EN
  // True when digit idx and every more-significant digit are zero.
  function automatic logic upper_zero(input logic [15:0] v, input digit_idx_t idx);
    return (v >> {idx, 2'b00}) == 16'h0000;
  endfunction
`endif

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Load/ack handshake plus the digit-drive outputs of hex_scan_ctrl.
// master: the producer of display values; slave: the scan controller.
interface hex_scan_ctrl_if;
  import hex_pkg::*;

  logic                  Load;
  logic [15:0]           Value;
  logic                  Ack;
  nibble_t               Nibble;
  logic [NUM_DIGITS-1:0] DigitSel_n;
  logic                  Blank;
  logic                  FrameDone;

  modport master (
    output Load, Value,
    input  Ack, Nibble, DigitSel_n, Blank, FrameDone
  );

  modport slave (
    input  Load, Value,
    output Ack, Nibble, DigitSel_n, Blank, FrameDone
  );

endinterface

// File: rtl/hex_scan_ctrl_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 while enabled, held at 0 otherwise.
// Tick is high on the cycle the count sits at DIV-1.
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic En,
  output logic Tick
);

  localparam int              W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]    LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign Tick = En && (cnt_q == LAST);

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    cnt_d = '0;
    if (En && !Tick) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: registers use <= so all of them sample the pre-edge values together.
  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Four-digit hex display scan controller with double-buffered, frame-aligned updates.
// Define HEX_SCAN_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module hex_scan_ctrl
  import hex_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic           Clk,
  input  logic           Reset,
  hex_scan_ctrl_if.slave bus
);

  scan_state_e           state_q, state_d;
  digit_idx_t            idx_q, idx_d;
  logic [15:0]           shadow_q, shadow_d;
  logic [15:0]           pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  nibble_t               nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0] sel_n_q, sel_n_d;
  logic                  blank_q, blank_d;
  logic                  ack_q, ack_d;
  logic                  frame_q, frame_d;
  logic                  tick, boundary;

  scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (state_q == SCAN),
    .Tick  (tick)
  );

  assign boundary = tick && (idx_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    frame_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Load) begin
          state_d    = SCAN;
          idx_d      = '0;
          shadow_d   = bus.Value;
          pend_vld_d = 1'b0;
          ack_d      = 1'b1;
        end
      end
      SCAN: begin
        if (tick) idx_d = idx_q + 2'd1;
        // A load landing on the boundary bypasses the pending buffer.
        if (boundary) begin
          frame_d = 1'b1;
          if (bus.Load) begin
            shadow_d   = bus.Value;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
          end else if (pend_vld_q) begin
            shadow_d   = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
          end
        end else if (bus.Load) begin
          pend_d     = bus.Value;
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Digit drive is taken from next-state values so it lines up with idx.
    nibble_d = '0;
    sel_n_d  = '1;
    blank_d  = 1'b1;
    if (state_d == SCAN) begin
      nibble_d = nibble_at(shadow_d, idx_d);
      sel_n_d  = ~(NUM_DIGITS'(1) << idx_d);
`ifdef HEX_SCAN_LZ_BLANK_EN
      blank_d  = (idx_d != '0) && upper_zero(shadow_d, idx_d);
`else
      blank_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      nibble_q   <= '0;
      sel_n_q    <= '1;
      blank_q    <= 1'b1;
      ack_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      nibble_q   <= nibble_d;
      sel_n_q    <= sel_n_d;
      blank_q    <= blank_d;
      ack_q      <= ack_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.Ack        = ack_q;
  assign bus.Nibble     = nibble_q;
  assign bus.DigitSel_n = sel_n_q;
  assign bus.Blank      = blank_q;
  assign bus.FrameDone  = frame_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl (SCAN_DIV=4): vector table, directed
// corner sequences and randomized traffic against a cycle-count based model.
module tb_hex_scan_ctrl;

  localparam int DIV = 4;
`ifdef HEX_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hex_scan_ctrl_if bus ();

  hex_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish act=running req=done");
    $fatal(1, "timeout");
  end

  // Reference model: display position derived from edges since activation.
  bit          m_active = 1'b0;
  int          m_cyc    = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_pend [$];
  bit          m_ack    = 1'b0;
  bit          m_fd     = 1'b0;

  task automatic model_edge(input bit r, input bit load, input logic [15:0] val);
    m_ack = 1'b0;
    m_fd  = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_cyc    = 0;
      m_shadow = '0;
      m_pend.delete();
    end else if (!m_active) begin
      if (load) begin
        m_active = 1'b1;
        m_cyc    = 0;
        m_shadow = val;
        m_pend.delete();
        m_ack    = 1'b1;
      end
    end else begin
      m_cyc++;
      if (m_cyc % (4 * DIV) == 0) begin
        m_fd = 1'b1;
        if (load) begin
          m_shadow = val;
          m_pend.delete();
          m_ack = 1'b1;
        end else if (m_pend.size() > 0) begin
          m_shadow = m_pend[$];
          m_pend.delete();
          m_ack = 1'b1;
        end
      end else if (load) begin
        m_pend.push_back(val);
      end
    end
  endtask

  function automatic logic [10:0] model_out();
    int          d;
    logic [15:0] s;
    logic [3:0]  sel;
    bit          bl;
    if (!m_active) return {m_ack, m_fd, 1'b1, 4'hF, 4'h0};
    d   = (m_cyc / DIV) % 4;
    s   = m_shadow >> (4 * d);
    sel = 4'b0001 << d;
    bl  = LZ && (d > 0) && (s == 16'h0000);
    return {m_ack, m_fd, bl, ~sel, s[3:0]};
  endfunction

  function automatic logic [10:0] dut_out();
    return {bus.Ack, bus.FrameDone, bus.Blank, bus.DigitSel_n, bus.Nibble};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit load, input logic [15:0] val);
    @(negedge clk);
    rst       = r;
    bus.Load  = load;
    bus.Value = val;
    @(posedge clk);
    model_edge(r, load, val);
    #1;
  endtask

  task automatic mchk(input string tag);
    check($sformatf("%s_model{ack,fd,blank,sel,nib}", tag), dut_out(), model_out());
  endtask

  task automatic step(input string tag, input bit r, input bit load, input logic [15:0] val);
    cycle(r, load, val);
    mchk(tag);
  endtask

  typedef struct {
    bit          rst;
    bit          load;
    logic [15:0] value;
    int          n;
    bit          ack;
    bit          fd;
    logic [3:0]  sel;
    logic [3:0]  nib;
    bit          blank;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t v(input bit r, input bit l, input logic [15:0] val, input int n,
                             input bit a, input bit f, input logic [3:0] s,
                             input logic [3:0] nb, input bit b);
    vec_t x;
    x.rst = r; x.load = l; x.value = val; x.n = n;
    x.ack = a; x.fd = f; x.sel = s; x.nib = nb; x.blank = b;
    return x;
  endfunction

  int          acks;
  bit          fd_seen;
  bit          ack_with_fd;
  logic [3:0]  exp_frame [4];
  logic [15:0] rv;

  initial begin
    bus.Load  = 1'b0;
    bus.Value = '0;

    // Basic scan of 1A2F, mid-frame reset, then all-zero and 0050 values.
    tbl.push_back(v(1, 0, 16'h0000, 2, 0, 0, 4'hF, 4'h0, 1));
    tbl.push_back(v(0, 1, 16'h1A2F, 1, 1, 0, 4'hE, 4'hF, 0));
    tbl.push_back(v(0, 0, 16'h0000, 3, 0, 0, 4'hE, 4'hF, 0));
    tbl.push_back(v(0, 0, 16'h0000, 4, 0, 0, 4'hD, 4'h2, 0));
    tbl.push_back(v(0, 0, 16'h0000, 4, 0, 0, 4'hB, 4'hA, 0));
    tbl.push_back(v(0, 0, 16'h0000, 4, 0, 0, 4'h7, 4'h1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 1, 4'hE, 4'hF, 0));
    tbl.push_back(v(0, 0, 16'h0000, 3, 0, 0, 4'hE, 4'hF, 0));
    tbl.push_back(v(1, 1, 16'hFFFF, 1, 0, 0, 4'hF, 4'h0, 1));
    tbl.push_back(v(0, 1, 16'h0000, 1, 1, 0, 4'hE, 4'h0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 3, 0, 0, 4'hE, 4'h0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 4, 0, 0, 4'hD, 4'h0, LZ));
    tbl.push_back(v(0, 0, 16'h0000, 4, 0, 0, 4'hB, 4'h0, LZ));
    tbl.push_back(v(0, 0, 16'h0000, 4, 0, 0, 4'h7, 4'h0, LZ));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 1, 4'hE, 4'h0, 0));
    tbl.push_back(v(1, 0, 16'h0000, 1, 0, 0, 4'hF, 4'h0, 1));
    tbl.push_back(v(0, 1, 16'h0050, 1, 1, 0, 4'hE, 4'h0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 3, 0, 0, 4'hE, 4'h0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 4, 0, 0, 4'hD, 4'h5, 0));
    tbl.push_back(v(0, 0, 16'h0000, 4, 0, 0, 4'hB, 4'h0, LZ));
    tbl.push_back(v(0, 0, 16'h0000, 4, 0, 0, 4'h7, 4'h0, LZ));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        cycle(tbl[i].rst, tbl[i].load, tbl[i].value);
        check($sformatf("vec%0d.%0d{ack,fd,blank,sel,nib}", i, k), dut_out(),
              {tbl[i].ack, tbl[i].fd, tbl[i].blank, tbl[i].sel, tbl[i].nib});
        mchk($sformatf("vec%0d.%0d", i, k));
      end
    end

    // Two mid-frame loads: latest wins, a single Ack together with FrameDone.
    step("r031", 1, 0, 16'h0000);
    step("r031", 0, 1, 16'h1A2F);
    repeat (5) step("r031", 0, 0, 16'h0000);
    step("r031", 0, 1, 16'h0003);
    step("r031", 0, 0, 16'h0000);
    step("r031", 0, 1, 16'h0004);
    acks = 0; fd_seen = 1'b0; ack_with_fd = 1'b0;
    for (int k = 0; k < 40 && !fd_seen; k++) begin
      step("r031w", 0, 0, 16'h0000);
      if (bus.Ack) acks++;
      if (bus.FrameDone) begin
        fd_seen     = 1'b1;
        ack_with_fd = bus.Ack;
      end
    end
    check("req031_framedone_seen", fd_seen, 1);
    check("req031_ack_count", acks, 1);
    check("req031_ack_with_framedone", ack_with_fd, 1);
    exp_frame = '{4'h4, 4'h0, 4'h0, 4'h0};
    for (int d = 0; d < 4; d++) begin
      check($sformatf("req031_digit%0d_nibble", d), bus.Nibble, exp_frame[d]);
      if (d < 3) repeat (DIV) step("r031f", 0, 0, 16'h0000);
    end

    // Load exactly on the idx==3 tick commits directly.
    step("r032", 1, 0, 16'h0000);
    step("r032", 0, 1, 16'h1A2F);
    repeat (4 * DIV - 1) step("r032", 0, 0, 16'h0000);
    step("r032", 0, 1, 16'h0BEE);
    check("req032_ack", bus.Ack, 1);
    check("req032_framedone", bus.FrameDone, 1);
    check("req032_nibble", bus.Nibble, 4'hE);
    acks = 0;
    repeat (4 * DIV) begin
      step("r032t", 0, 0, 16'h0000);
      if (bus.Ack) acks++;
    end
    check("req032_no_extra_ack", acks, 0);

    // Reset on digit 2 with a commit pending discards the commit.
    step("r033", 1, 0, 16'h0000);
    step("r033", 0, 1, 16'h1A2F);
    repeat (5) step("r033", 0, 0, 16'h0000);
    step("r033", 0, 1, 16'h5555);
    repeat (3) step("r033", 0, 0, 16'h0000);
    check("req033_on_digit2", bus.DigitSel_n, 4'hB);
    cycle(1, 0, 16'h0000);
    check("req033_sel_after_reset", bus.DigitSel_n, 4'hF);
    check("req033_blank_after_reset", bus.Blank, 1);
    check("req033_ack_after_reset", bus.Ack, 0);
    acks = 0;
    repeat (6 * DIV) begin
      step("r033t", 0, 0, 16'h0000);
      if (bus.Ack) acks++;
    end
    check("req033_no_ack_follows", acks, 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 1500; t++) begin
      rv = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rv &= 16'h000F;
        1:       rv &= 16'h00FF;
        2:       rv &= 16'h0FF0;
        default: ;
      endcase
      step("rand", ($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
